// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int SKID = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCCUPANCY
);
    logic              main_v, skid_v, push, pop;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    // with the skid buffer, ready depends only on registers, cutting the OUT_READY path
    always_comb begin
        IN_READY  = RESET & ~BUSYWAIT & ((SKID != 0) ? ~skid_v : (~main_v | OUT_READY));
        push      = IN_VALID & IN_READY & ~BUSYWAIT;
        pop       = main_v & OUT_READY & ~BUSYWAIT;
        OUT_VALID = main_v;
        OUT_DATA  = main_data;
        OUT_CTRL  = main_v ? main_ctrl : CTRL_NOP;
        OCCUPANCY = {1'b0, main_v} + {1'b0, skid_v};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (FLUSH) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if ((SKID != 0) && pop && skid_v) begin
            main_v    <= 1'b1;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_v    <= 1'b0;
        end else if ((SKID == 0) || pop || !main_v) begin
            main_v <= push | (main_v & ~pop);
            if (push) begin
                main_data <= IN_DATA;
                main_ctrl <= IN_CTRL;
            end
        end else if (push) begin
            skid_v    <= 1'b1;
            skid_data <= IN_DATA;
            skid_ctrl <= IN_CTRL;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench checking SKID=1 and SKID=0 stages against a queue model
module tb_pipe_stage_reg;
    localparam logic [7:0] NOP = 8'h5A;

    logic        CLK = 1'b0, RESET = 1'b0, BUSYWAIT = 1'b0, FLUSH = 1'b0;
    logic        IN_VALID = 1'b1, OUT_READY = 1'b0;
    logic [15:0] IN_DATA = 16'h0099;
    logic [7:0]  IN_CTRL = 8'h99 ^ 8'h3C;
    logic        rdy1, ov1, rdy0, ov0;
    logic [15:0] od1, od0;
    logic [7:0]  oc1, oc0;
    logic [1:0]  occ1, occ0;

    int errs = 0, checks = 0;
    logic [15:0] q1d[$], q0d[$], seen[$];
    logic [7:0]  q1c[$], q0c[$];
    logic        p1, o1, p0, o0;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(NOP), .SKID(1)) u1 (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy1), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
        .OUT_VALID(ov1), .OUT_READY(OUT_READY), .OUT_DATA(od1), .OUT_CTRL(oc1), .OCCUPANCY(occ1));

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(NOP), .SKID(0)) u0 (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy0), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
        .OUT_VALID(ov0), .OUT_READY(OUT_READY), .OUT_DATA(od0), .OUT_CTRL(oc0), .OCCUPANCY(occ0));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one cycle of stimulus, applied on the falling edge
    task automatic cyc(input logic rst, input logic v, input logic [15:0] d,
                       input logic ordy, input logic bw, input logic fl);
        @(negedge CLK);
        RESET = rst; IN_VALID = v; IN_DATA = d; IN_CTRL = d[7:0] ^ 8'h3C;
        OUT_READY = ordy; BUSYWAIT = bw; FLUSH = fl;
    endtask

    // model: each stage is a bounded FIFO (2 entries with skid, 1 without)
    always @(posedge CLK) begin
        p1 = IN_VALID & RESET & ~BUSYWAIT & (q1d.size() < 2);
        o1 = (q1d.size() > 0) & OUT_READY & ~BUSYWAIT;
        p0 = IN_VALID & RESET & ~BUSYWAIT & ((q0d.size() == 0) | OUT_READY);
        o0 = (q0d.size() > 0) & OUT_READY & ~BUSYWAIT;
        if (!RESET || FLUSH) begin
            q1d.delete(); q1c.delete(); q0d.delete(); q0c.delete();
        end else begin
            if (o1) begin seen.push_back(q1d.pop_front()); void'(q1c.pop_front()); end
            if (p1) begin q1d.push_back(IN_DATA); q1c.push_back(IN_CTRL); end
            if (o0) begin void'(q0d.pop_front()); void'(q0c.pop_front()); end
            if (p0) begin q0d.push_back(IN_DATA); q0c.push_back(IN_CTRL); end
        end
    end

    always @(negedge CLK) begin
        #2;
        chk("ov1", ov1, q1d.size() > 0);
        chk("ctl1", oc1, (q1d.size() > 0) ? q1c[0] : NOP);
        if (q1d.size() > 0) chk("dat1", od1, q1d[0]);
        chk("occ1", occ1, q1d.size());
        chk("rdy1", rdy1, RESET & ~BUSYWAIT & (q1d.size() < 2));
        chk("ov0", ov0, q0d.size() > 0);
        chk("ctl0", oc0, (q0d.size() > 0) ? q0c[0] : NOP);
        if (q0d.size() > 0) chk("dat0", od0, q0d[0]);
        chk("occ0", occ0, q0d.size());
        chk("rdy0", rdy0, RESET & ~BUSYWAIT & ((q0d.size() == 0) | OUT_READY));
    end

    initial begin
        cyc(0, 1, 16'h99, 0, 0, 0);
        cyc(0, 1, 16'h99, 0, 0, 0);
        #1;
        chk("rst_ov", ov1, 0);
        chk("rst_ctl", oc1, NOP);
        chk("rst_occ", occ1, 0);
        chk("rst_dat", od1, 0);
        chk("rst_rdy1", rdy1, 0);
        chk("rst_rdy0", rdy0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        #1 chk("rel_rdy", rdy1, 1);

        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 16'(i), 1, 0, 0);
            if (i > 1) chk("stream_dat", od1, i - 1);
        end
        cyc(1, 0, 0, 1, 0, 0);
        chk("stream_last", od1, 8);
        cyc(1, 0, 0, 1, 0, 0);
        chk("stream_cnt", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk("stream_ord", seen[i], i + 1);
        seen.delete();

        cyc(1, 1, 16'h11, 1, 0, 0);
        cyc(1, 1, 16'h12, 0, 0, 0);
        cyc(1, 1, 16'h13, 0, 0, 0);
        chk("bp_full", occ1, 2);
        #1 chk("bp_rdy", rdy1, 0);
        cyc(1, 1, 16'h13, 0, 0, 0);
        cyc(1, 1, 16'h13, 1, 0, 0);
        cyc(1, 1, 16'h13, 1, 0, 0);
        chk("bp_pop", od1, 16'h12);
        #1 chk("bp_recover", rdy1, 1);
        cyc(1, 1, 16'h14, 1, 0, 0);
        cyc(1, 1, 16'h15, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 1, 0, 0);
        chk("bp_cnt", seen.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_ord", seen[i], 16'h11 + i);
        seen.delete();

        cyc(1, 1, 16'h21, 0, 0, 0);
        cyc(1, 1, 16'h22, 0, 0, 0);
        cyc(1, 1, 16'h23, 0, 0, 1);
        chk("fl_pre", occ1, 2);
        cyc(1, 0, 0, 1, 0, 0);
        chk("fl_ov", ov1, 0);
        chk("fl_ctl", oc1, NOP);
        chk("fl_occ", occ1, 0);
        chk("fl_ov0", ov0, 0);
        repeat (2) cyc(1, 0, 0, 1, 0, 0);
        chk("fl_gone", seen.size(), 0);

        cyc(1, 1, 16'h51, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 0, 0);
        chk("flbw_ov", ov1, 0);
        chk("flbw_occ", occ1, 0);

        cyc(1, 1, 16'h31, 1, 0, 0);
        cyc(1, 1, 16'h32, 1, 1, 0);
        #1 chk("bw_rdy", rdy1, 0);
        cyc(1, 1, 16'h32, 1, 1, 0);
        cyc(1, 1, 16'h32, 1, 1, 0);
        chk("bw_dat", od1, 16'h31);
        chk("bw_occ", occ1, 1);
        cyc(1, 1, 16'h32, 1, 0, 0);
        cyc(1, 1, 16'h33, 1, 0, 0);
        chk("bw_resume", od1, 16'h32);
        cyc(1, 0, 0, 1, 0, 0);
        chk("bw_next", od1, 16'h33);
        cyc(1, 0, 0, 1, 0, 0);

        cyc(1, 1, 16'h61, 0, 0, 0);
        cyc(1, 1, 16'h62, 0, 0, 0);
        cyc(0, 1, 16'h63, 0, 0, 0);
        chk("mid_pre", occ1, 2);
        cyc(1, 0, 0, 1, 0, 0);
        chk("mid_occ", occ1, 0);
        chk("mid_ov", ov1, 0);
        chk("mid_occ0", occ0, 0);

        cyc(1, 1, 16'h41, 0, 0, 0);
        cyc(1, 1, 16'h42, 0, 0, 0);
        #1 chk("s0_block", rdy0, 0);
        OUT_READY = 1'b1;
        #1 chk("s0_comb", rdy0, 1);
        cyc(1, 0, 0, 1, 0, 0);
        chk("s0_swap", od0, 16'h42);
        chk("s0_occ", occ0, 1);
        chk("s1_swap", od1, 16'h42);
        repeat (2) cyc(1, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the per-boundary hand-written stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque payload bus plus a control bus. A valid/ready handshake gives per-stage back-pressure. An optional 2-entry skid buffer breaks the combinational ready path. FLUSH inserts bubbles: control is forced to a NOP pattern. The global BUSYWAIT stall from the memory system is still honoured.

## Interface
- DATA_W, 128: payload width (PC, operands, immediate, rd, ...).
- CTRL_W, 24: control-field width (ALU op, selects, mem R/W, WB select, reg-write enable).
- CTRL_NOP, 0: control pattern driven for a bubble; must encode reg-write 0 and mem R/W idle.
- SKID, 1: 1 = 2-entry skid buffer, registered IN_READY; 0 = single register, combinational IN_READY.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset (RESET==0 at a rising CLK edge resets).
- BUSYWAIT  in  1  global stall; freezes all state.
- FLUSH  in  1  invalidate all held entries (branch/jump mispredict).
- IN_VALID  in  1  upstream entry valid.
- IN_READY  out  1  stage can accept.
- IN_DATA  in  DATA_W  upstream payload.
- IN_CTRL  in  CTRL_W  upstream control.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  DATA_W  head payload.
- OUT_CTRL  out  CTRL_W  head control; CTRL_NOP whenever OUT_VALID==0.
- OCCUPANCY  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Storage: main entry (drives OUT_*). If SKID=1, there is also a skid entry. Each entry has a valid bit.
- push = IN_VALID & IN_READY & !BUSYWAIT. pop = OUT_VALID & OUT_READY & !BUSYWAIT.
- IN_READY:
  - SKID=0: RESET & !BUSYWAIT & (!main_v | OUT_READY).
  - SKID=1: RESET & !BUSYWAIT & !skid_v. This uses register-only terms; it has no OUT_READY path.
- SKID=1 update rules, when not BUSYWAIT and not FLUSH:
  - pop & skid_v: main <= skid, skid_v <= 0. No push is possible.
  - pop & !skid_v: main <= push ? IN : invalid.
  - !pop & !main_v: main <= push ? IN : invalid.
  - !pop & main_v & push: skid <= IN, skid_v <= 1.
- SKID=0: on push, main <= IN. Otherwise, on pop, main_v <= 0.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by FLUSH or RESET.
- FLUSH (RESET high): main_v <= 0 and skid_v <= 0, regardless of BUSYWAIT. An entry offered on the same edge is discarded. The upstream push is still counted as taken, so the producer must also be flushed.
- BUSYWAIT high without FLUSH: no state changes. OUT_* hold their values. IN_READY = 0.
- OUT_CTRL = main_v ? main_ctrl : CTRL_NOP; this is combinational from state.
- OUT_DATA = main_data. It holds its last value when invalid; its contents are don't-care while OUT_VALID=0.
- OCCUPANCY = main_v + skid_v.
- Priority: RESET > FLUSH > BUSYWAIT > handshake.

## Timing
- Reset values (edge with RESET=0): OUT_VALID 0, OUT_CTRL CTRL_NOP, OUT_DATA 0, OCCUPANCY 0, skid cleared.
- IN_READY is 0 while RESET is low, and 1 on the cycle after release if BUSYWAIT=0.
- Latency: an entry pushed at edge N appears on OUT_* after edge N (one cycle). Throughput is 1 entry/cycle with OUT_READY held high.
- SKID=1, OUT_READY falls with the stage full-streaming:
  - The entry pushed that edge lands in skid.
  - IN_READY drops after that edge, then recovers one cycle after the first pop.
- A reset mid-stream, at any occupancy, empties the stage in one edge. Held entries are lost.
- Simultaneous FLUSH and BUSYWAIT: flush takes effect; OUT_VALID=0 on the next cycle.

## Test plan
- Reset: assert RESET=0 for 2 cycles with IN_VALID=1 -> OUT_VALID=0, OUT_CTRL=CTRL_NOP, OCCUPANCY=0, IN_READY=0. After release, IN_READY=1.
- Streaming (SKID=1): push IN_DATA=1..8 on consecutive cycles with OUT_READY=1 -> OUT_DATA=1..8 on consecutive cycles, each 1 cycle after its push, no gaps.
- Back-pressure: stream 1..5 with OUT_READY=0 on cycles 2-4 -> OCCUPANCY reaches 2, IN_READY=0 while full. Output order is 1,2,3,4,5 with no loss.
- Flush: occupancy 2 (entries A,B), pulse FLUSH with IN_VALID=1 (C) -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_NOP, OCCUPANCY=0. A, B and C never appear.
- BUSYWAIT: hold BUSYWAIT=1 for 3 cycles with OUT_READY=1, IN_VALID=1 -> OUT_* and OCCUPANCY frozen, IN_READY=0. Streaming resumes one cycle after release.
- SKID=0 build: OUT_READY=0 with main full -> IN_READY=0 in the same cycle. OUT_READY=1 -> IN_READY=1 combinationally, and pop and push happen on the same edge.
